// File: rtl/i2c_master_byte_ctrl_pkg.sv
// i2c_master_byte_ctrl_pkg: shared types and widths for the single-byte I2C master
package i2c_master_byte_ctrl_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  typedef enum logic [3:0] {IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, MNACK, STOP} state_t;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;
endpackage

// File: rtl/i2c_master_byte_ctrl_if.sv
// i2c_master_byte_ctrl_if: command/response bundle between a requester and the I2C master
interface i2c_master_byte_ctrl_if;
  import i2c_master_byte_ctrl_pkg::*;
  logic                  i_start;
  logic [I2C_ADDR_W-1:0] i_addr;
  logic                  i_rw;
  logic [I2C_DATA_W-1:0] i_wdata;
  logic [I2C_DATA_W-1:0] o_rdata;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_nack;
  modport master (output i_start, i_addr, i_rw, i_wdata, input o_rdata, o_busy, o_done, o_nack);
  modport slave (input i_start, i_addr, i_rw, i_wdata, output o_rdata, o_busy, o_done, o_nack);
endinterface

// File: rtl/i2c_master_byte_ctrl_tick_gen.sv
// i2c_master_byte_ctrl_tick_gen: one-cycle tick every CLK_DIV cycles while enabled
module i2c_master_byte_ctrl_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  output logic o_tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] r_cnt;
  assign o_tick = i_en && r_cnt == W'(CLK_DIV - 1);
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_cnt <= '0;
    else r_cnt <= (!i_en || o_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// i2c_master_byte_ctrl: single-byte I2C master (START, addr+rw, ACK, data byte, ACK/NACK, STOP)
module i2c_master_byte_ctrl
  import i2c_master_byte_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  i2c_master_byte_ctrl_if.slave cmd,
  output logic                  o_scl,
  inout  wire                   io_sda
);
  state_t   r_state, w_next;
  quarter_t r_q;
  logic [2:0] r_bit;
  logic [7:0] r_sh, r_wdata, r_rdata;
  logic r_rw, r_done, r_nack;
  logic w_tick, w_last, w_sample, w_oe, w_sda, w_accept;
  i2c_master_byte_ctrl_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_en     (r_state != IDLE),
    .o_tick   (w_tick)
  );
  assign w_sda = io_sda;
  assign io_sda = w_oe ? 1'b0 : 1'bz;
  assign w_accept = r_state == IDLE && cmd.i_start && !r_done;
  assign w_last = w_tick && r_q == Q3;
  assign w_sample = w_tick && r_q == Q2;
  assign o_scl = (r_state == IDLE || r_state == START) ? 1'b1 : r_q[1];
  assign cmd.o_busy = r_state != IDLE || r_done;
  assign cmd.o_done = r_done;
  assign cmd.o_nack = r_nack;
  assign cmd.o_rdata = r_rdata;
  always_comb begin
    w_next = r_state;
    w_oe = 1'b0;
    case (r_state)
      IDLE:  w_next = w_accept ? START : IDLE;
      START: begin
        w_oe = r_q[1];
        w_next = w_last ? ADDR : START;
      end
      ADDR: begin
        w_oe = !r_sh[7];
        w_next = (w_last && r_bit == 3'd0) ? AACK : ADDR;
      end
      AACK:  w_next = !w_last ? AACK : r_nack ? STOP : r_rw ? RDATA : WDATA;
      WDATA: begin
        w_oe = !r_sh[7];
        w_next = (w_last && r_bit == 3'd0) ? WACK : WDATA;
      end
      WACK:  w_next = w_last ? STOP : WACK;
      RDATA: w_next = (w_last && r_bit == 3'd0) ? MNACK : RDATA;
      MNACK: w_next = w_last ? STOP : MNACK;
      STOP: begin
        w_oe = r_q != Q3;
        w_next = w_last ? IDLE : STOP;
      end
      default: w_next = IDLE;
    endcase
  end
  // r_bit wraps 0->7 at each byte end, so it is ready for the next byte without a reload
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_q <= Q0;
      r_bit <= 3'd7;
      r_sh <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rw <= 1'b0;
      r_done <= 1'b0;
      r_nack <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= r_state == STOP && w_last;
      if (w_tick) r_q <= quarter_t'(r_q + 2'd1);
      if (w_accept) begin
        r_sh <= {cmd.i_addr, cmd.i_rw};
        r_rw <= cmd.i_rw;
        r_wdata <= cmd.i_wdata;
        r_nack <= 1'b0;
      end
      if (w_sample && (r_state == AACK || r_state == WACK) && w_sda) r_nack <= 1'b1;
      if (w_sample && r_state == RDATA) begin
        r_sh <= {r_sh[6:0], w_sda};
        if (r_bit == 3'd0) r_rdata <= {r_sh[6:0], w_sda};
      end
      if (w_last && (r_state == ADDR || r_state == WDATA || r_state == RDATA)) r_bit <= r_bit - 3'd1;
      if (w_last && (r_state == ADDR || r_state == WDATA)) r_sh <= {r_sh[6:0], 1'b0};
      if (w_last && r_state == AACK) r_sh <= r_wdata;
    end
endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// tb_i2c_master_byte_ctrl: behavioural slave + bus-trace scoreboard for the single-byte I2C master
module tb_i2c_master_byte_ctrl;
  localparam int T_START = 1000;
  localparam int T_STOP = 1001;
  localparam logic [6:0] SLV = 7'h50;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic o_scl;
  wire  sda;
  logic slv_oe = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  int checks = 0;
  int failures = 0;
  int exp_q[$];
  pullup (sda);
  assign sda = slv_oe ? 1'b0 : 1'bz;
  i2c_master_byte_ctrl_if cmd ();
  i2c_master_byte_ctrl #(.CLK_DIV(4)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .cmd      (cmd.slave),
    .o_scl    (o_scl),
    .io_sda   (sda)
  );
  always #5 clk = ~clk;
  function automatic int ftok(input logic [7:0] b, input logic ack);
    return (int'(b) << 1) | int'(ack);
  endfunction
  task automatic emit(input int tok);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL trace: got token %0d, expected none", tok);
    end else begin
      e = exp_q.pop_front();
      if (tok !== e) begin
        failures++;
        $display("FAIL trace: got token %0d, expected %0d", tok, e);
      end
    end
  endtask
  // Bus monitor and slave: samples on negedge, decodes START/STOP and 9-bit frames
  logic p_scl = 1'b1, p_sda = 1'b1;
  int bitn = 0, byte_n = 0;
  logic [8:0] frame = '0;
  logic rd_mode = 1'b0, addr_ok = 1'b0;
  always @(negedge clk) begin
    p_scl <= o_scl;
    p_sda <= sda;
    if (p_scl && o_scl && p_sda !== sda) begin
      emit(sda ? T_STOP : T_START);
      if (!sda) begin
        bitn <= 0;
        byte_n <= 0;
      end
    end
    if (!p_scl && o_scl) begin
      frame <= {frame[7:0], sda};
      bitn <= bitn + 1;
      if (bitn == 8) emit(int'({frame[7:0], sda}));
    end
    if (p_scl && !o_scl) begin
      if (bitn == 9) begin
        bitn <= 0;
        byte_n <= byte_n + 1;
        slv_oe <= rd_mode && addr_ok && byte_n == 0 && !rd_byte[7];
      end else if (bitn == 8 && byte_n == 0) begin
        addr_ok <= frame[7:1] == SLV;
        rd_mode <= frame[0];
        slv_oe <= frame[7:1] == SLV;
      end else if (bitn == 8) slv_oe <= !rd_mode;
      else slv_oe <= rd_mode && addr_ok && byte_n == 1 && bitn < 8 && !rd_byte[7-bitn];
    end
  end
  task automatic run_xfer(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                          input int inject, output int cyc, output logic busy1);
    @(negedge clk);
    cmd.i_start = 1'b1;
    cmd.i_addr = a;
    cmd.i_rw = rw;
    cmd.i_wdata = wd;
    cyc = 0;
    busy1 = 1'b0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = cmd.o_busy;
      cmd.i_start = cyc == inject;
      if (cyc == inject) begin
        cmd.i_addr = 7'h11;
        cmd.i_rw = ~rw;
        cmd.i_wdata = ~wd;
      end
      if (cmd.o_done) break;
    end
    cmd.i_start = 1'b0;
  endtask
  task automatic check_drained(input string name);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_trace_left: %0d tokens pending, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask
  task automatic test_reset;
    cmd.i_start = 1'b0;
    cmd.i_addr = '0;
    cmd.i_rw = 1'b0;
    cmd.i_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (cmd.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", cmd.o_busy); end
    if (cmd.o_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", cmd.o_done); end
    if (cmd.o_nack !== 1'b0) begin failures++; $display("FAIL reset_nack: got %b want 0", cmd.o_nack); end
    if (cmd.o_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h want 00", cmd.o_rdata); end
    if (o_scl !== 1'b1) begin failures++; $display("FAIL reset_scl: got %b want 1", o_scl); end
    if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda: got %b want 1", sda); end
  endtask
  task automatic test_write;
    int cyc;
    logic b1;
    exp_q.push_back(T_START);
    exp_q.push_back(ftok(8'hA0, 1'b0));
    exp_q.push_back(ftok(8'hA5, 1'b0));
    exp_q.push_back(T_STOP);
    run_xfer(SLV, 1'b0, 8'hA5, 0, cyc, b1);
    checks += 4;
    if (b1 !== 1'b1) begin failures++; $display("FAIL write_busy_c1: got %b want 1", b1); end
    if (cyc !== 321) begin failures++; $display("FAIL write_done_cycle: got %0d want 321", cyc); end
    if (cmd.o_nack !== 1'b0) begin failures++; $display("FAIL write_nack: got %b want 0", cmd.o_nack); end
    if (cmd.o_busy !== 1'b1) begin failures++; $display("FAIL write_busy_done: got %b want 1", cmd.o_busy); end
    @(negedge clk);
    checks++;
    if (cmd.o_busy !== 1'b0) begin failures++; $display("FAIL write_busy_after: got %b want 0", cmd.o_busy); end
    check_drained("write");
  endtask
  task automatic test_read;
    int cyc;
    logic b1;
    rd_byte = 8'h3C;
    exp_q.push_back(T_START);
    exp_q.push_back(ftok(8'hA1, 1'b0));
    exp_q.push_back(ftok(8'h3C, 1'b1));
    exp_q.push_back(T_STOP);
    run_xfer(SLV, 1'b1, 8'h00, 0, cyc, b1);
    checks += 3;
    if (cyc !== 321) begin failures++; $display("FAIL read_done_cycle: got %0d want 321", cyc); end
    if (cmd.o_rdata !== 8'h3C) begin failures++; $display("FAIL read_rdata: got %h want 3c", cmd.o_rdata); end
    if (cmd.o_nack !== 1'b0) begin failures++; $display("FAIL read_nack: got %b want 0", cmd.o_nack); end
    check_drained("read");
  endtask
  task automatic test_addr_nack;
    int cyc;
    logic b1;
    exp_q.push_back(T_START);
    exp_q.push_back(ftok(8'h46, 1'b1));
    exp_q.push_back(T_STOP);
    run_xfer(7'h23, 1'b0, 8'h77, 0, cyc, b1);
    checks += 3;
    if (cyc !== 177) begin failures++; $display("FAIL nack_done_cycle: got %0d want 177", cyc); end
    if (cmd.o_nack !== 1'b1) begin failures++; $display("FAIL nack_flag: got %b want 1", cmd.o_nack); end
    if (cmd.o_rdata !== 8'h3C) begin failures++; $display("FAIL nack_rdata_hold: got %h want 3c", cmd.o_rdata); end
    check_drained("nack");
  endtask
  task automatic test_busy_ignore;
    int cyc;
    logic b1;
    exp_q.push_back(T_START);
    exp_q.push_back(ftok(8'hA0, 1'b0));
    exp_q.push_back(ftok(8'hA5, 1'b0));
    exp_q.push_back(T_STOP);
    run_xfer(SLV, 1'b0, 8'hA5, 100, cyc, b1);
    checks += 2;
    if (cyc !== 321) begin failures++; $display("FAIL ignore_done_cycle: got %0d want 321", cyc); end
    if (cmd.o_nack !== 1'b0) begin failures++; $display("FAIL ignore_nack: got %b want 0", cmd.o_nack); end
    check_drained("ignore");
  endtask
  task automatic test_back_to_back;
    int cyc;
    logic b1;
    rd_byte = 8'hC3;
    exp_q.push_back(T_START);
    exp_q.push_back(ftok(8'hA0, 1'b0));
    exp_q.push_back(ftok(8'h5A, 1'b0));
    exp_q.push_back(T_STOP);
    run_xfer(SLV, 1'b0, 8'h5A, 0, cyc, b1);
    cmd.i_start = 1'b1;
    cmd.i_rw = 1'b1;
    @(negedge clk);
    cmd.i_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd.o_busy !== 1'b0) begin failures++; $display("FAIL b2b_start_on_done: busy %b want 0", cmd.o_busy); end
    check_drained("b2b_first");
    exp_q.push_back(T_START);
    exp_q.push_back(ftok(8'hA1, 1'b0));
    exp_q.push_back(ftok(8'hC3, 1'b1));
    exp_q.push_back(T_STOP);
    run_xfer(SLV, 1'b1, 8'h00, 0, cyc, b1);
    checks += 2;
    if (cyc !== 321) begin failures++; $display("FAIL b2b_done_cycle: got %0d want 321", cyc); end
    if (cmd.o_rdata !== 8'hC3) begin failures++; $display("FAIL b2b_rdata: got %h want c3", cmd.o_rdata); end
    check_drained("b2b_second");
  endtask
  task automatic test_reset_mid;
    int dones;
    dones = 0;
    exp_q.push_back(T_START);
    exp_q.push_back(ftok(8'hA0, 1'b0));
    @(negedge clk);
    cmd.i_start = 1'b1;
    cmd.i_addr = SLV;
    cmd.i_rw = 1'b0;
    cmd.i_wdata = 8'hA5;
    @(negedge clk);
    cmd.i_start = 1'b0;
    repeat (225) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (sda !== 1'b1) begin failures++; $display("FAIL rstmid_sda: got %b want 1", sda); end
    if (o_scl !== 1'b1) begin failures++; $display("FAIL rstmid_scl: got %b want 1", o_scl); end
    if (cmd.o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", cmd.o_busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (cmd.o_done) dones++;
    end
    checks += 2;
    if (dones !== 0) begin failures++; $display("FAIL rstmid_done: got %0d pulses want 0", dones); end
    if (cmd.o_rdata !== 8'h00) begin failures++; $display("FAIL rstmid_rdata: got %h want 00", cmd.o_rdata); end
    check_drained("rstmid");
  endtask
  initial begin
    test_reset;
    test_write;
    test_read;
    test_addr_nack;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
